// File: rtl/sys_update_pkg.sv
// ---------------------------------------------------------------------------
// sys_update_pkg
// Shared definitions for the remote-update controller: command opcode
// encoding, controller FSM states, default wait limits and field widths.
// No ports (package).
// ---------------------------------------------------------------------------
package sys_update_pkg;

    // Command opcodes as carried on cmd_op
    typedef enum logic [1:0] {
        OP_READ        = 2'd0,
        OP_WRITE       = 2'd1,
        OP_RECONFIG    = 2'd2,
        OP_RESET_TIMER = 2'd3
    } op_e;

    // Controller FSM states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_RESP    = 3'd4
    } state_e;

    // Default wait limits, in clock cycles
    localparam int DEF_TIMEOUT_CYC = 1024;
    localparam int DEF_START_WIN   = 4;

    // Field widths shared by the controller and its users
    localparam int PARAM_W  = 3;
    localparam int SOURCE_W = 2;
    localparam int DIN_W    = 24;
    localparam int DOUT_W   = 29;

endpackage

// File: rtl/sys_update_timer.sv
// ---------------------------------------------------------------------------
// sys_update_timer
// Saturating cycle counter used to bound the busy-rise window and the
// busy-fall timeout. The count never wraps; it sticks at LIMIT.
//
// Ports:
//   clock   in   sole clock
//   reset   in   synchronous active-high reset, clears the count
//   clr     in   clear the count to zero (wins over en)
//   en      in   advance the count by one (saturating)
//   count   out  current count, $clog2(LIMIT+1) bits
//   expired out  high while count has reached LIMIT-1, i.e. the current
//                cycle is the LIMIT-th cycle since the last clear
// ---------------------------------------------------------------------------
module sys_update_timer
    import sys_update_pkg::*;
#(
    parameter int LIMIT = DEF_TIMEOUT_CYC,
    parameter int CNT_W = $clog2(LIMIT + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIMIT - 1);

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

    // The count is zero in the first cycle after a clear, so the LIMIT-th
    // cycle is the one where it equals LIMIT-1.
    assign expired = (count >= CNT_LAST);

endmodule

// File: rtl/sys_update_ctrl.sv
// ---------------------------------------------------------------------------
// sys_update_ctrl
// Command sequencer for a remote-update IP. Accepts one command at a time,
// pulses the matching IP strobe for one cycle, tracks the IP busy handshake
// (rise within START_WIN cycles, fall within TIMEOUT_CYC cycles) and returns
// the captured IP data (or a timeout flag) on a valid/ready response port.
//
// Ports:
//   clock, reset              sole clock, synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake (ready only in IDLE)
//   cmd_op                    0=READ 1=WRITE 2=RECONFIG 3=RESET_TIMER
//   cmd_param/source/data     command fields, registered on accept
//   rsp_valid/rsp_ready       response handshake
//   rsp_data, rsp_err         captured IP data, timeout flag
//   ru_param/read_source/data_in  held command fields to the IP
//   ru_read_param/write_param/reconfig/reset_timer  one-cycle strobes
//   ru_reset                  IP reset, mirrors controller reset
//   ru_busy, ru_data_out      IP status and read data
// ---------------------------------------------------------------------------
module sys_update_ctrl
    import sys_update_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int START_WIN   = DEF_START_WIN
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [2:0]  cmd_param,
    input  logic [1:0]  cmd_source,
    input  logic [23:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [28:0] rsp_data,
    output logic        rsp_err,
    output logic [2:0]  ru_param,
    output logic [1:0]  ru_read_source,
    output logic [23:0] ru_data_in,
    output logic        ru_read_param,
    output logic        ru_write_param,
    output logic        ru_reconfig,
    output logic        ru_reset_timer,
    output logic        ru_reset,
    input  logic        ru_busy,
    input  logic [28:0] ru_data_out
);

    localparam int               CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] HI_LAST = CNT_W'(START_WIN - 1);

    state_e state, state_next;

    op_e                 op_q;
    logic [PARAM_W-1:0]  param_q;
    logic [SOURCE_W-1:0] source_q;
    logic [DIN_W-1:0]    data_q;
    logic [DOUT_W-1:0]   rsp_data_q;
    logic                rsp_err_q;

    logic             accept;
    logic             hi_expired;
    logic             lo_expired;
    logic             tmr_clr;
    logic             tmr_en;
    logic [CNT_W-1:0] tmr_count;

    assign accept = cmd_valid && cmd_ready;

    // One counter serves both wait states: it is cleared on the cycle that
    // enters WAIT_HI (ISSUE) and on the cycle that enters WAIT_LO.
    assign tmr_clr    = (state == ST_ISSUE) || ((state == ST_WAIT_HI) && ru_busy);
    assign tmr_en     = (state == ST_WAIT_HI) || (state == ST_WAIT_LO);
    assign hi_expired = (tmr_count >= HI_LAST);

    sys_update_timer #(
        .LIMIT (TIMEOUT_CYC),
        .CNT_W (CNT_W)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .count   (tmr_count),
        .expired (lo_expired)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_next = (op_q == OP_RESET_TIMER) ? ST_RESP : ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (ru_busy)         state_next = ST_WAIT_LO;
                else if (hi_expired) state_next = ST_RESP;
            end
            ST_WAIT_LO: begin
                // Busy falling is checked first so a fall on the last
                // allowed cycle still counts as a success.
                if (!ru_busy || lo_expired) state_next = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Command capture on accept; response capture on the transition into
    // RESP. Both are pure data and only meaningful behind the FSM state.
    always_ff @(posedge clock) begin
        if (accept) begin
            op_q     <= op_e'(cmd_op);
            param_q  <= cmd_param;
            source_q <= cmd_source;
            data_q   <= cmd_data;
        end
        case (state)
            ST_ISSUE: begin
                if (op_q == OP_RESET_TIMER) begin
                    rsp_data_q <= '0;
                    rsp_err_q  <= 1'b0;
                end
            end
            ST_WAIT_HI: begin
                if (!ru_busy && hi_expired) begin
                    rsp_data_q <= ru_data_out;
                    rsp_err_q  <= 1'b0;
                end
            end
            ST_WAIT_LO: begin
                if (!ru_busy) begin
                    rsp_data_q <= ru_data_out;
                    rsp_err_q  <= 1'b0;
                end else if (lo_expired) begin
                    rsp_data_q <= '0;
                    rsp_err_q  <= 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Outputs: everything is forced to its reset value while reset is high,
    // regardless of where the FSM was when reset arrived.
    always_comb begin
        cmd_ready      = 1'b0;
        rsp_valid      = 1'b0;
        rsp_data       = '0;
        rsp_err        = 1'b0;
        ru_param       = '0;
        ru_read_source = '0;
        ru_data_in     = '0;
        ru_read_param  = 1'b0;
        ru_write_param = 1'b0;
        ru_reconfig    = 1'b0;
        ru_reset_timer = 1'b0;
        ru_reset       = 1'b0;
        if (reset) begin
            ru_reset = 1'b1;
        end else begin
            ru_param       = param_q;
            ru_read_source = source_q;
            ru_data_in     = data_q;
            case (state)
                ST_IDLE: cmd_ready = 1'b1;
                ST_ISSUE: begin
                    case (op_q)
                        OP_READ:        ru_read_param  = 1'b1;
                        OP_WRITE:       ru_write_param = 1'b1;
                        OP_RECONFIG:    ru_reconfig    = 1'b1;
                        OP_RESET_TIMER: ru_reset_timer = 1'b1;
                        default: ;
                    endcase
                end
                ST_RESP: begin
                    rsp_valid = 1'b1;
                    rsp_data  = rsp_data_q;
                    rsp_err   = rsp_err_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sys_update_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sys_update_ctrl
// Directed bench for sys_update_ctrl with TIMEOUT_CYC=16, START_WIN=4.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge. Cycle numbers count from the accept cycle (cycle 0).
// ---------------------------------------------------------------------------
module tb_sys_update_ctrl;

    localparam int TO = 16;
    localparam int SW = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [2:0]  cmd_param = '0;
    logic [1:0]  cmd_source = '0;
    logic [23:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [28:0] rsp_data;
    logic        rsp_err;
    logic [2:0]  ru_param;
    logic [1:0]  ru_read_source;
    logic [23:0] ru_data_in;
    logic        ru_read_param;
    logic        ru_write_param;
    logic        ru_reconfig;
    logic        ru_reset_timer;
    logic        ru_reset;
    logic        ru_busy = 1'b0;
    logic [28:0] ru_data_out = '0;

    int n_tests = 0;
    int n_fail  = 0;

    sys_update_ctrl #(
        .TIMEOUT_CYC (TO),
        .START_WIN   (SW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_param      (cmd_param),
        .cmd_source     (cmd_source),
        .cmd_data       (cmd_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_err        (rsp_err),
        .ru_param       (ru_param),
        .ru_read_source (ru_read_source),
        .ru_data_in     (ru_data_in),
        .ru_read_param  (ru_read_param),
        .ru_write_param (ru_write_param),
        .ru_reconfig    (ru_reconfig),
        .ru_reset_timer (ru_reset_timer),
        .ru_reset       (ru_reset),
        .ru_busy        (ru_busy),
        .ru_data_out    (ru_data_out)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a command; it is accepted on the next rising edge.
    task automatic send(input logic [1:0] op, input logic [2:0] p,
                        input logic [1:0] s, input logic [23:0] d, input string tag);
        cmd_op = op; cmd_param = p; cmd_source = s; cmd_data = d;
        cmd_valid = 1'b1;
        @(negedge clock);
        check_eq({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        tick();
        // Scramble the command bus so held outputs must come from registers
        cmd_valid = 1'b0;
        cmd_op = ~op; cmd_param = ~p; cmd_source = ~s; cmd_data = ~d;
    endtask

    // Drive the IP model from cycle 1 until rsp_valid appears. Busy is high
    // on cycles [bstart, bstart+blen) (blen<0: stuck high). data_out shows a
    // junk pattern while busy and dout otherwise. Returns with the bench at
    // the falling edge of the first RESP cycle, or lat=-1 if none arrived.
    task automatic run_rsp(input int bstart, input int blen, input logic [28:0] dout,
                           input logic [1:0] op, output int lat, output int strobe_cyc,
                           output int n_sel, output int n_all);
        logic [3:0] stb;
        logic       b;
        lat = -1; strobe_cyc = -1; n_sel = 0; n_all = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            b = (cyc >= bstart) && ((blen < 0) || (cyc < bstart + blen));
            ru_busy     = b;
            ru_data_out = b ? 29'h15555555 : dout;
            @(negedge clock);
            stb = {ru_reset_timer, ru_reconfig, ru_write_param, ru_read_param};
            n_all += int'(stb[0]) + int'(stb[1]) + int'(stb[2]) + int'(stb[3]);
            if (stb[op]) n_sel++;
            if ((stb != 4'b0) && (strobe_cyc < 0)) strobe_cyc = cyc;
            if (rsp_valid) begin
                lat = cyc;
                break;
            end
            tick();
        end
    endtask

    // Full transaction: command, IP behaviour, response checks, optional
    // back-pressure for `hold` cycles, handshake and return to IDLE.
    task automatic txn(input string tag, input logic [1:0] op, input logic [2:0] p,
                       input logic [1:0] s, input logic [23:0] d,
                       input int bstart, input int blen, input logic [28:0] dout,
                       input int exp_lat, input logic [28:0] exp_data, input logic exp_err,
                       input int hold);
        int  lat, scyc, n_sel, n_all;
        bit  held_ok;
        send(op, p, s, d, tag);
        run_rsp(bstart, blen, dout, op, lat, scyc, n_sel, n_all);
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_strobe_cyc"}, 32'(scyc), 32'd1);
        check_eq({tag, "_strobe_sel"}, 32'(n_sel), 32'd1);
        check_eq({tag, "_strobe_all"}, 32'(n_all), 32'd1);
        if (lat < 0) begin
            ru_busy = 1'b0;
            return;
        end
        check_eq({tag, "_data"}, 32'(rsp_data), 32'(exp_data));
        check_eq({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        check_eq({tag, "_fields"}, {8'h0, ru_param, ru_read_source, ru_data_in[18:0]},
                 {8'h0, p, s, d[18:0]});
        check_eq({tag, "_din_hi"}, 32'(ru_data_in[23:19]), 32'(d[23:19]));
        held_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            @(negedge clock);
            if (!rsp_valid || rsp_data !== exp_data || rsp_err !== exp_err ||
                cmd_ready || ru_param !== p || ru_data_in !== d)
                held_ok = 1'b0;
        end
        if (hold > 0) check_eq({tag, "_held"}, 32'(held_ok), 32'd1);
        tick();
        rsp_ready = 1'b1;
        @(negedge clock);
        check_eq({tag, "_hs_valid"}, 32'(rsp_valid), 32'd1);
        check_eq({tag, "_hs_noready"}, 32'(cmd_ready), 32'd0);
        tick();
        rsp_ready = 1'b0;
        ru_busy   = 1'b0;
        @(negedge clock);
        check_eq({tag, "_idle_valid"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, "_idle_ready"}, 32'(cmd_ready), 32'd1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit quiet_ok;

        // Reset values
        repeat (3) tick();
        @(negedge clock);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
        check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
        check_eq("rst_ru_reset", 32'(ru_reset), 32'd1);
        check_eq("rst_strobes", {28'h0, ru_reset_timer, ru_reconfig, ru_write_param, ru_read_param}, 32'd0);
        check_eq("rst_fields", {3'h0, ru_param, ru_read_source, ru_data_in}, 32'd0);
        reset = 1'b0;
        tick();
        @(negedge clock);
        check_eq("post_rst_ready", 32'(cmd_ready), 32'd1);
        check_eq("post_rst_ru_reset", 32'(ru_reset), 32'd0);
        tick();

        // READ: busy on cycles 2..4, falls on 5 -> RESP on 6
        txn("read", 2'd0, 3'h4, 2'h1, 24'h5A5A5A, 2, 3, 29'h0ABCDEF, 6, 29'h0ABCDEF, 1'b0, 0);
        // Inert IP WRITE: busy never rises -> RESP on START_WIN+2, data 0
        txn("write_inert", 2'd1, 3'h2, 2'h2, 24'h123456, 99, 0, 29'h0, SW + 2, 29'h0, 1'b0, 0);
        // RECONFIG: busy rises on the last window cycle (5), falls on 7 -> RESP on 8
        txn("reconfig_win", 2'd2, 3'h7, 2'h3, 24'hABCDEF, 5, 2, 29'h1234567, 8, 29'h1234567, 1'b0, 0);
        // Busy rises one cycle too late: window ends on 5 capturing data_out,
        // and busy high during RESP is ignored
        txn("late_busy", 2'd0, 3'h1, 2'h0, 24'h0F0F0F, 6, 3, 29'h0F0F0F0, 6, 29'h0F0F0F0, 1'b0, 2);
        // Timeout: busy stuck high, WAIT_LO on cycles 3..18 -> RESP on 19
        txn("timeout", 2'd0, 3'h5, 2'h2, 24'h777777, 2, -1, 29'h1ABCDEF, 19, 29'h0, 1'b1, 0);
        // Busy falls on the 16th WAIT_LO cycle (18): success, not timeout
        txn("fall_at_limit", 2'd0, 3'h3, 2'h1, 24'h246802, 2, 16, 29'h0777777, 19, 29'h0777777, 1'b0, 0);
        // Back-pressure: 10 cycles with rsp_ready low
        txn("backpressure", 2'd1, 3'h5, 2'h0, 24'hC0FFEE, 2, 1, 29'h0DEAD00, 4, 29'h0DEAD00, 1'b0, 10);
        // RESET_TIMER: straight to RESP, data 0 even with data_out nonzero
        txn("reset_timer", 2'd3, 3'h1, 2'h2, 24'h111111, 99, 0, 29'h1FFFFFF, 2, 29'h0, 1'b0, 0);

        // Reset in WAIT_LO: busy held high, reset on cycle 5
        send(2'd0, 3'h6, 2'h2, 24'h0A0B0C, "abort");
        ru_busy = 1'b1;
        ru_data_out = 29'h1234567;
        repeat (4) tick();
        reset = 1'b1;
        @(negedge clock);
        check_eq("abort_rst_valid", 32'(rsp_valid), 32'd0);
        check_eq("abort_rst_ready", 32'(cmd_ready), 32'd0);
        check_eq("abort_rst_ru_reset", 32'(ru_reset), 32'd1);
        check_eq("abort_rst_fields", {3'h0, ru_param, ru_read_source, ru_data_in}, 32'd0);
        check_eq("abort_rst_rsp", {2'h0, rsp_err, rsp_data}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        ru_busy = 1'b0;
        quiet_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (rsp_valid || !cmd_ready || ru_reset) quiet_ok = 1'b0;
            tick();
        end
        check_eq("abort_no_rsp", 32'(quiet_ok), 32'd1);
        txn("read_after_abort", 2'd0, 3'h3, 2'h1, 24'h00BEEF, 2, 3, 29'h0ABCDEF, 6, 29'h0ABCDEF, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
